// File: rtl/pipeline_scoreboard.sv
// Register scoreboard for in-order issue: per-register latency counters,
// RAW/WAW stall generation, execute-flush cancel and a saturating stall counter.
//
// Ports:
//   clk, rst             clock, synchronous active-high reset
//   issue_valid          decode requests issue
//   rs1_d/rs1_use        source 1 index and use flag
//   rs2_d/rs2_use        source 2 index and use flag
//   rd_d/rd_we/lat_d     destination, write flag, result latency
//   flush_e              cancel the reservation made by last cycle's issue
//   stall_d, issue_ok    hazard stall and issue grant (combinational)
//   busy                 registered per-register pending mask
//   stall_cycles         registered saturating count of stalled cycles
module pipeline_scoreboard #(
  parameter int NREG   = 32,
  parameter int AW     = 5,
  parameter int LATW   = 3,
  parameter int FWD_EN = 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            issue_valid,
  input  logic [AW-1:0]   rs1_d,
  input  logic            rs1_use,
  input  logic [AW-1:0]   rs2_d,
  input  logic            rs2_use,
  input  logic [AW-1:0]   rd_d,
  input  logic            rd_we,
  input  logic [LATW-1:0] lat_d,
  input  logic            flush_e,
  output logic            stall_d,
  output logic            issue_ok,
  output logic [NREG-1:0] busy,
  output logic [31:0]     stall_cycles
);

  typedef logic [LATW-1:0] cnt_t;

  localparam cnt_t ONE = cnt_t'(1);
  localparam cnt_t THR = cnt_t'((FWD_EN != 0) ? 1 : 0);

  cnt_t            cnt_q [NREG];
  cnt_t            cnt_d [NREG];
  logic [NREG-1:0] busy_q;
  logic [NREG-1:0] busy_d;
  logic            rec_vld_q;
  logic [AW-1:0]   rec_rd_q;
  logic [31:0]     sc_q;

  cnt_t lat_eff;
  logic raw1;
  logic raw2;
  logic waw;
  logic set_en;
  logic clr_en;

  assign lat_eff = (lat_d == '0) ? ONE : lat_d;

  // Hazards look only at the current counters; a same-cycle
  // issue or flush takes effect from the next cycle.
  assign raw1 = rs1_use && (rs1_d != '0)
                && (cnt_q[rs1_d] > THR);
  assign raw2 = rs2_use && (rs2_d != '0)
                && (cnt_q[rs2_d] > THR);
  assign waw  = rd_we && (rd_d != '0)
                && (cnt_q[rd_d] > ONE);

  assign stall_d  = issue_valid & (raw1 | raw2 | waw);
  assign issue_ok = issue_valid & ~stall_d;

  assign set_en = issue_ok & rd_we & (rd_d != '0);
  assign clr_en = flush_e & rec_vld_q;

  // Priority per register: new reservation > flush > decrement.
  always_comb begin
    for (int r = 0; r < NREG; r++) begin
      cnt_d[r] = (cnt_q[r] != '0) ? cnt_q[r] - ONE : '0;
      if (clr_en && (rec_rd_q == AW'(r)))
        cnt_d[r] = '0;
      if (set_en && (rd_d == AW'(r)))
        cnt_d[r] = lat_eff;
      if (r == 0)
        cnt_d[r] = '0;
      busy_d[r] = (cnt_d[r] != '0);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int r = 0; r < NREG; r++)
        cnt_q[r] <= '0;
      busy_q    <= '0;
      rec_vld_q <= 1'b0;
      rec_rd_q  <= '0;
      sc_q      <= '0;
    end else begin
      for (int r = 0; r < NREG; r++)
        cnt_q[r] <= cnt_d[r];
      busy_q    <= busy_d;
      rec_vld_q <= set_en;
      if (set_en)
        rec_rd_q <= rd_d;
      if (stall_d && (sc_q != '1))
        sc_q <= sc_q + 32'd1;
    end
  end

  assign busy         = busy_q;
  assign stall_cycles = sc_q;

endmodule
